aes_subbytes_serial: RTL and testbench

- Byte-serial masked SubBytes sequencer sitting directly upstream and downstream of the pipelined DOM AES S-box.
- Accepts a full shared 128-bit AES state and streams its 16 bytes into the S-box, one byte per cycle.
- Collects the S-box outputs, reassembles the shared 128-bit result and hands it to the round logic over a valid/ready handshake.
- Also tells the PRNG when fresh masks must be presented to the S-box.

---
 rtl/aes_masked_pkg.sv | 14 +
 rtl/valid_delay_line.sv | 31 +++
 rtl/aes_subbytes_serial.sv | 104 ++++++++++
 tb/tb_aes_subbytes_serial.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_masked_pkg.sv
// Shared constants and FSM encoding for the byte-serial masked AES datapath.
package aes_masked_pkg;

    localparam int AES_NUM_BYTES = 16;
    localparam int BYTE_IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sbSerState_t;

endpackage

// File: rtl/valid_delay_line.sv
// In-flight valid tracker for pipelined masked gadgets: vldPipe[0] is the entry
// tap, vldPipe[STAGES] the tail; DEPTH counts both taps, so DEPTH must be >= 2.
module valid_delay_line #(
    parameter int DEPTH = 5
) (
    input  logic ClkxCI,
    input  logic RstxBI,
    input  logic InxSI,
    output logic OutxSO,
    output logic BusyxSO
);

    localparam int STAGES = DEPTH - 1;

    logic [STAGES:1] vldQ;
    logic [STAGES:0] vldPipe;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            vldQ <= '0;
        end else begin
            for (int i = STAGES; i >= 2; i--) vldQ[i] <= vldQ[i-1];
            vldQ[1] <= InxSI;
        end
    end

    assign vldPipe = {vldQ, InxSI};
    assign OutxSO  = vldPipe[STAGES];
    assign BusyxSO = |vldPipe;

endmodule

// File: rtl/aes_subbytes_serial.sv
// Byte-serial SubBytes sequencer around the pipelined DOM S-box: feeds the 16
// bytes of a shared state one per cycle and reassembles the shared result.
module aes_subbytes_serial
    import aes_masked_pkg::*;
#(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 5
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic [128*SHARES-1:0]   _StatexDI,
    input  logic                    InValidxSI,
    output logic                    InReadyxSO,
    output logic [8*SHARES-1:0]     _SboxInxDO,
    input  logic [8*SHARES-1:0]     _SboxOutxDI,
    output logic                    RandReqxSO,
    output logic [128*SHARES-1:0]   _StatexDO,
    output logic                    OutValidxSO,
    input  logic                    OutReadyxSI
);

    sbSerState_t stateQ, stateD;

    logic [BYTE_IDX_W-1:0] feedCntQ, feedCntNxt, collCntQ;
    logic [SHARES-1:0][AES_NUM_BYTES-1:0][7:0] stateIn, inStateQ, outStateQ;
    logic [SHARES-1:0][7:0] sboxInQ, sboxInD, sboxOut;

    logic inAccept, outAccept, feedAct, lastFeed, collVld, lastColl, busy;

    assign stateIn = _StatexDI;
    assign sboxOut = _SboxOutxDI;

    assign inAccept   = InValidxSI & InReadyxSO;
    assign outAccept  = OutValidxSO & OutReadyxSI;
    assign feedAct    = (stateQ == FEED);
    assign lastFeed   = feedAct && (feedCntQ == BYTE_IDX_W'(AES_NUM_BYTES - 1));
    assign lastColl   = collVld && (collCntQ == BYTE_IDX_W'(AES_NUM_BYTES - 1));
    assign feedCntNxt = feedCntQ + BYTE_IDX_W'(1);

    valid_delay_line #(
        .DEPTH (SBOX_LATENCY)
    ) u_inflight (
        .ClkxCI  (ClkxCI),
        .RstxBI  (RstxBI),
        .InxSI   (feedAct),
        .OutxSO  (collVld),
        .BusyxSO (busy)
    );

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (inAccept)  stateD = FEED;
            FEED:    if (lastFeed)  stateD = DRAIN;
            DRAIN:   if (lastColl)  stateD = DONE;
            DONE:    if (outAccept) stateD = IDLE;
            default:                stateD = IDLE;
        endcase
    end

    // The S-box port is loaded one edge ahead, so byte FeedCnt is on the port
    // during the FEED cycle that owns it; every other cycle it is forced to zero.
    always_comb begin
        sboxInD = '0;
        for (int i = 0; i < SHARES; i++) begin
            if (inAccept)
                sboxInD[i] = stateIn[i][0];
            else if (feedAct && !lastFeed)
                sboxInD[i] = inStateQ[i][feedCntNxt];
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            stateQ    <= IDLE;
            feedCntQ  <= '0;
            collCntQ  <= '0;
            inStateQ  <= '0;
            outStateQ <= '0;
            sboxInQ   <= '0;
        end else begin
            stateQ  <= stateD;
            sboxInQ <= sboxInD;
            if (inAccept) begin
                inStateQ <= stateIn;
                feedCntQ <= '0;
            end else if (feedAct) begin
                feedCntQ <= feedCntNxt;
            end
            // Per-share insert at the tail; the counter wraps back to 0 after byte 15.
            if (collVld) begin
                for (int i = 0; i < SHARES; i++) outStateQ[i][collCntQ] <= sboxOut[i];
                collCntQ <= collCntQ + BYTE_IDX_W'(1);
            end
        end
    end

    assign InReadyxSO  = (stateQ == IDLE);
    assign OutValidxSO = (stateQ == DONE);
    assign RandReqxSO  = busy;
    assign _SboxInxDO  = sboxInQ;
    assign _StatexDO   = outStateQ;

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Bench for aes_subbytes_serial with a behavioural masked S-box and SubBytes reference.
module tb_aes_subbytes_serial;

    localparam int SHARES = 2;
    localparam int LAT    = 5;

    logic         ClkxCI = 1'b0;
    logic         RstxBI = 1'b0;
    logic [255:0] stateIn = '0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [15:0]  sboxIn;
    logic [15:0]  sboxOut;
    logic         randReq;
    logic [255:0] stateOut;
    logic         outValid;
    logic         outReady = 1'b0;

    int nChk  = 0;
    int nFail = 0;

    always #5 ClkxCI = ~ClkxCI;

    aes_subbytes_serial #(.SHARES(SHARES), .SBOX_LATENCY(LAT)) dut (
        .ClkxCI      (ClkxCI),
        .RstxBI      (RstxBI),
        ._StatexDI   (stateIn),
        .InValidxSI  (inValid),
        .InReadyxSO  (inReady),
        ._SboxInxDO  (sboxIn),
        ._SboxOutxDI (sboxOut),
        .RandReqxSO  (randReq),
        ._StatexDO   (stateOut),
        .OutValidxSO (outValid),
        .OutReadyxSI (outReady)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sboxRef(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] refSubBytes(input logic [127:0] p);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = sboxRef(p[8*b +: 8]);
        return r;
    endfunction

    // Masked S-box model: output in cycle c is a fresh sharing of S(x), x presented in cycle c-(LAT-1).
    logic [15:0] hist [0:LAT-2];
    logic [7:0]  maskQ;
    bit          maskEn = 1'b0;

    always @(posedge ClkxCI) begin
        for (int i = LAT - 2; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= sboxIn;
        maskQ   <= (maskEn && randReq) ? 8'($urandom) : 8'h00;
    end

    assign sboxOut = {maskQ, sboxRef(hist[LAT-2][7:0] ^ hist[LAT-2][15:8]) ^ maskQ};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] s0;
        logic [127:0] s1;
        logic [127:0] expXor;
        bit           rndMask;
        bit           chkLeak;
        int           bp;
    } vec_t;

    task automatic runOp(input vec_t v, input string tag);
        int n = 0, lat = 0, rrCnt = 0;
        bit streamOk = 1'b1, leakOk = 1'b1, bpOk = 1'b1;
        logic [127:0] plain = v.s0 ^ v.s1;
        logic [255:0] held;
        logic [15:0]  expIn;
        maskEn   = v.rndMask;
        outReady = (v.bp == 0);
        stateIn  = {v.s1, v.s0};
        inValid  = 1'b1;
        chk({tag, " in_ready_idle"}, 128'(inReady), 128'd1);
        if (sboxIn !== 16'h0) streamOk = 1'b0;
        @(negedge ClkxCI);
        inValid = 1'b0;
        n = 1;
        while (lat == 0 && n <= 60) begin
            rrCnt += int'(randReq);
            if (n <= 16) begin
                expIn = {v.s1[8*(n-1) +: 8], v.s0[8*(n-1) +: 8]};
                if (sboxIn !== expIn) streamOk = 1'b0;
                if (sboxIn[7:0] == plain[8*(n-1) +: 8] || sboxIn[15:8] == plain[8*(n-1) +: 8])
                    leakOk = 1'b0;
            end else if (sboxIn !== 16'h0) begin
                streamOk = 1'b0;
            end
            if (outValid) lat = n;
            else begin
                @(negedge ClkxCI);
                n++;
            end
        end
        chk({tag, " latency"}, 128'(lat), 128'd21);
        chk({tag, " randreq_cycles"}, 128'(rrCnt), 128'd20);
        chk({tag, " sbox_in_stream"}, 128'(streamOk), 128'd1);
        if (v.chkLeak) chk({tag, " no_unmasked_byte"}, 128'(leakOk), 128'd1);
        chk({tag, " result_xor"}, stateOut[127:0] ^ stateOut[255:128], v.expXor);
        held = stateOut;
        if (v.bp > 0) begin
            for (int i = 0; i < v.bp; i++) begin
                @(negedge ClkxCI);
                if (stateOut !== held || inReady !== 1'b0 || outValid !== 1'b1) bpOk = 1'b0;
            end
            chk({tag, " backpressure_hold"}, 128'(bpOk), 128'd1);
            outReady = 1'b1;
        end
        @(negedge ClkxCI);
        chk({tag, " idle_after_handoff"}, 128'({inReady, outValid}), 128'b10);
        chk({tag, " result_kept"}, stateOut[127:0] ^ stateOut[255:128], v.expXor);
        outReady = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        logic [127:0] ptxt = 128'h0f0e0d0c0b0a09080706050403020100;
        logic [127:0] spec = 128'h76abd7fe2b670130c56f6bf27b777c63;
        logic [127:0] a5s  = {16{8'ha5}};
        logic [127:0] p, m;
        int acc = 0, hand = 0, rr = 0, feedLeft = 0;
        bit zeroOk = 1'b1;
        vec_t rv;

        vecs[0] = '{s0: ptxt,       s1: '0,  expXor: spec,           rndMask: 1'b0, chkLeak: 1'b0, bp: 0};
        vecs[1] = '{s0: ptxt ^ a5s, s1: a5s, expXor: spec,           rndMask: 1'b1, chkLeak: 1'b1, bp: 10};
        vecs[2] = '{s0: '0,         s1: '0,  expXor: {16{8'h63}},    rndMask: 1'b1, chkLeak: 1'b0, bp: 0};
        for (int k = 3; k < 6; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            m = {$urandom, $urandom, $urandom, $urandom};
            vecs[k] = '{s0: p ^ m, s1: m, expXor: refSubBytes(p), rndMask: 1'b1, chkLeak: 1'b0,
                        bp: int'($urandom_range(0, 3))};
        end

        // reset state
        repeat (2) @(negedge ClkxCI);
        chk("rst in_ready", 128'(inReady), 128'd1);
        chk("rst out_valid", 128'(outValid), 128'd0);
        chk("rst rand_req", 128'(randReq), 128'd0);
        chk("rst sbox_in", 128'(sboxIn), 128'd0);
        chk("rst state_out", stateOut[127:0] | stateOut[255:128], 128'd0);
        RstxBI = 1'b1;
        @(negedge ClkxCI);

        for (int k = 0; k < 6; k++) runOp(vecs[k], $sformatf("vec%0d", k));

        // asynchronous reset while FeedCnt = 7
        maskEn  = 1'b1;
        stateIn = {vecs[4].s1, vecs[4].s0};
        inValid = 1'b1;
        @(negedge ClkxCI);
        inValid = 1'b0;
        repeat (7) @(negedge ClkxCI);
        chk("midrst busy_before", 128'({randReq, inReady}), 128'b10);
        RstxBI = 1'b0;
        #1;
        chk("midrst in_ready", 128'(inReady), 128'd1);
        chk("midrst out_valid", 128'(outValid), 128'd0);
        chk("midrst rand_req", 128'(randReq), 128'd0);
        chk("midrst sbox_in", 128'(sboxIn), 128'd0);
        chk("midrst state_out", stateOut[127:0] | stateOut[255:128], 128'd0);
        @(negedge ClkxCI);
        RstxBI = 1'b1;
        rv = vecs[5];
        rv.bp = 0;
        runOp(rv, "after_rst");

        // InValid held high across two operations
        maskEn   = 1'b1;
        stateIn  = {vecs[3].s1, vecs[3].s0};
        inValid  = 1'b1;
        outReady = 1'b1;
        for (int c = 0; c < 44; c++) begin
            if (feedLeft > 0) feedLeft--;
            else if (sboxIn !== 16'h0) zeroOk = 1'b0;
            if (inValid && inReady) begin
                acc++;
                feedLeft = 16;
            end
            rr += int'(randReq);
            if (outValid && outReady) hand++;
            @(negedge ClkxCI);
        end
        inValid = 1'b0;
        chk("cont acceptances", 128'(acc), 128'd2);
        chk("cont handoffs", 128'(hand), 128'd2);
        chk("cont randreq_cycles", 128'(rr), 128'd40);
        chk("cont sbox_in_zero_idle", 128'(zeroOk), 128'd1);
        chk("cont result_xor", stateOut[127:0] ^ stateOut[255:128], vecs[3].expXor);
        outReady = 1'b0;
        repeat (2) @(negedge ClkxCI);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
